// File: rtl/tortoise_pkg.sv
// Shared types for the tortoise core: FU operations, privilege levels and the
// CSR commit-stage state encoding, plus CSR address field positions.
package tortoise_pkg;

  typedef enum logic [3:0] {
    CSR_READ   = 4'd0,
    CSR_WRITE  = 4'd1,
    CSR_SET    = 4'd2,
    CSR_CLEAR  = 4'd3,
    MRET       = 4'd4,
    SRET       = 4'd5,
    DRET       = 4'd6,
    WFI        = 4'd7,
    SFENCE_VMA = 4'd8
  } fu_op_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WB   = 2'd2,
    S_WFI  = 2'd3
  } csr_state_e;

  // CSR address fields: minimum privilege in [9:8], read-only marker in [11:10]
  localparam int unsigned CSR_PRIV_LSB = 8;
  localparam int unsigned CSR_PRIV_MSB = 9;
  localparam int unsigned CSR_RO_LSB   = 10;
  localparam int unsigned CSR_RO_MSB   = 11;
  localparam logic [1:0]  CSR_RO_VAL   = 2'b11;

  localparam int unsigned CAUSE_ILLEGAL_INSTR = 2;

  function automatic logic is_csr_op(input fu_op_t op);
    return (op == CSR_READ) || (op == CSR_WRITE) ||
           (op == CSR_SET)  || (op == CSR_CLEAR);
  endfunction

endpackage

// File: rtl/csr_commit_perm_check.sv
// Combinational CSR access permission check: existence, privilege level and
// write-to-read-only detection.
module csr_perm_check
  import tortoise_pkg::*;
(
  input  logic [11:0] addr_i,
  input  fu_op_t      op_i,
  input  priv_t       priv_i,
  input  logic        csr_exists_i,
  output logic        illegal_o
);

  logic priv_fail;
  logic ro_fail;

  assign priv_fail = addr_i[CSR_PRIV_MSB:CSR_PRIV_LSB] > 2'(priv_i);
  assign ro_fail   = (addr_i[CSR_RO_MSB:CSR_RO_LSB] == CSR_RO_VAL) && (op_i != CSR_READ);
  assign illegal_o = !csr_exists_i || priv_fail || ro_fail;

endmodule

// File: rtl/csr_commit.sv
// Commit-stage executor for FU_CSR entries: CSR read-modify-write, old-value
// writeback to the register file, xRET/SFENCE pulses and WFI stall.
module csr_commit
  import tortoise_pkg::*;
#(
  parameter int unsigned RV_XLEN = 64,
  parameter int unsigned XLEN    = RV_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            commit_valid_i,
  input  fu_op_t          commit_op_i,
  input  logic [4:0]      commit_rd_i,
  input  logic [XLEN-1:0] commit_op1_i,
  input  logic [XLEN-1:0] commit_op2_i,
  output logic            commit_ready_o,
  input  priv_t           priv_i,
  input  logic            flush_i,
  input  logic            irq_pending_i,
  output logic [11:0]     csr_addr_o,
  output logic            csr_re_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  input  logic            csr_exists_i,
  output logic            csr_we_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            done_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_cause_o,
  output logic            mret_o,
  output logic            sret_o,
  output logic            dret_o,
  output logic            sfence_o
);

  csr_state_e      state_q, state_d;
  fu_op_t          op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            illegal_q, illegal_d;
  logic            illegal;
  logic            accept;

  // Only the CSR address bits of op2 are consumed; the SFENCE asid is not forwarded.
  logic unused_op2_hi;
  assign unused_op2_hi = ^commit_op2_i[XLEN-1:12];

  assign accept = (state_q == S_IDLE) && commit_valid_i && !flush_i;

  csr_perm_check u_perm (
    .addr_i       (addr_q),
    .op_i         (op_q),
    .priv_i       (priv_i),
    .csr_exists_i (csr_exists_i),
    .illegal_o    (illegal)
  );

  function automatic logic [XLEN-1:0] csr_new_value(input fu_op_t op,
                                                    input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] src);
    case (op)
      CSR_WRITE: return src;
      CSR_SET:   return old | src;
      CSR_CLEAR: return old & ~src;
      default:   return old;
    endcase
  endfunction

  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    op1_d     = op1_q;
    addr_d    = addr_q;
    old_d     = old_q;
    illegal_d = illegal_q;
    if (accept) begin
      op_d   = commit_op_i;
      rd_d   = commit_rd_i;
      op1_d  = commit_op1_i;
      addr_d = commit_op2_i[11:0];
    end
    if (state_q == S_READ && !flush_i) begin
      old_d     = csr_rdata_i;
      illegal_d = illegal;
    end
  end

  always_comb begin
    state_d        = state_q;
    commit_ready_o = 1'b0;
    csr_re_o       = 1'b0;
    csr_we_o       = 1'b0;
    rf_we_o        = 1'b0;
    done_o         = 1'b0;
    ex_valid_o     = 1'b0;
    mret_o         = 1'b0;
    sret_o         = 1'b0;
    dret_o         = 1'b0;
    sfence_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        commit_ready_o = !flush_i;
        if (accept) begin
          if (is_csr_op(commit_op_i))  state_d = S_READ;
          else if (commit_op_i == WFI) state_d = S_WFI;
          else                         state_d = S_WB;
        end
      end
      S_READ: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          csr_re_o = !(op_q == CSR_WRITE && rd_q == 5'd0);
          state_d  = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_o = 1'b1;
          if (is_csr_op(op_q)) begin
            csr_we_o   = (op_q != CSR_READ) && !illegal_q;
            rf_we_o    = (rd_q != 5'd0) && !illegal_q;
            ex_valid_o = illegal_q;
          end else begin
            mret_o   = (op_q == MRET);
            sret_o   = (op_q == SRET);
            dret_o   = (op_q == DRET);
            sfence_o = (op_q == SFENCE_VMA);
          end
        end
      end
      S_WFI: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (irq_pending_i) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = csr_new_value(op_q, old_q, op1_q);
  assign rf_waddr_o  = rd_q;
  assign rf_wdata_o  = old_q;
  assign ex_cause_o  = ex_valid_o ? XLEN'(CAUSE_ILLEGAL_INSTR) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= CSR_READ;
      rd_q      <= '0;
      op1_q     <= '0;
      addr_q    <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      op1_q     <= op1_d;
      addr_q    <= addr_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
